// File: rtl/opfetch_pkg.sv
// Shared types and sizes for the operand fetch stage.
// Optional feature macro used by the top: OPFETCH_STALL_CNT_EN.
package opfetch_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } state_t;

  // An address is illegal when it is actually used and its top bit is set
  // (only the lower NUM_REGS registers exist).
  function automatic logic addr_illegal(input logic [ADDR_W-1:0] addr, input logic used);
    return used & addr[ADDR_W-1];
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set when an
// instruction leaves the stage with a destination, cleared on writeback.
// A set and a clear to the same bit on one edge resolve to set.
module opfetch_scoreboard
  import opfetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic [IDX_W-1:0]    query_a,
  input  logic [IDX_W-1:0]    query_b,
  input  logic                query_b_en,
  output logic [NUM_REGS-1:0] busy,
  output logic                hazard
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Writebacks aimed above the register file are ignored.
  assign set_vec = set_en ? (NUM_REGS'(1) << set_idx) : '0;
  assign clr_vec = (clr_en && !clr_addr[ADDR_W-1]) ?
                   (NUM_REGS'(1) << clr_addr[IDX_W-1:0]) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      // Per-register busy flag; set has priority over clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)            busy_reg[gi] <= 1'b0;
        else if (set_vec[gi]) busy_reg[gi] <= 1'b1;
        else if (clr_vec[gi]) busy_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  // Lookup uses the registered vector, so a same-cycle writeback only
  // unblocks on the following cycle.
  assign hazard = busy_reg[query_a] | (query_b_en & busy_reg[query_b]);
  assign busy   = busy_reg;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a decoded instruction, waits out RAW hazards
// against the scoreboard, reads the register bank (registered data, one cycle
// later) and presents operands to execute with a valid/ready handshake.
// Optional: define OPFETCH_STALL_CNT_EN to add a saturating stall_count output.
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [ADDR_W-1:0]   src_a,
  input  logic [ADDR_W-1:0]   src_b,
  input  logic                src_b_en,
  input  logic [ADDR_W-1:0]   dst,
  input  logic                dst_en,
  output logic                read_1EN,
  output logic                read_2EN,
  output logic [ADDR_W-1:0]   read_1,
  output logic [ADDR_W-1:0]   read_2,
  input  logic [DATA_W-1:0]   line_a,
  input  logic [DATA_W-1:0]   line_b,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [ADDR_W-1:0]   op_dst,
  output logic                op_dst_en,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                addr_err
`ifdef OPFETCH_STALL_CNT_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   src_a_reg, src_b_reg, dst_reg;
  logic                src_b_en_reg, dst_en_reg;
  logic [DATA_W-1:0]   op_a_reg, op_b_reg;
  logic [ADDR_W-1:0]   op_dst_reg;
  logic                op_dst_en_reg;
  logic                hazard;
  logic                addr_bad;
  logic                retire;

  assign addr_bad = addr_illegal(src_a_reg, 1'b1)
                  | addr_illegal(src_b_reg, src_b_en_reg)
                  | addr_illegal(dst_reg, dst_en_reg);

  assign retire = (state_reg == OUT) && op_ready;

  opfetch_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (retire && op_dst_en_reg),
    .set_idx    (op_dst_reg[IDX_W-1:0]),
    .clr_en     (wb_valid),
    .clr_addr   (wb_addr),
    .query_a    (src_a_reg[IDX_W-1:0]),
    .query_b    (src_b_reg[IDX_W-1:0]),
    .query_b_en (src_b_en_reg),
    .busy       (busy),
    .hazard     (hazard)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Latch the offered instruction on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_a_reg    <= '0;
      src_b_reg    <= '0;
      src_b_en_reg <= 1'b0;
      dst_reg      <= '0;
      dst_en_reg   <= 1'b0;
    end else if (state_reg == IDLE && instr_valid) begin
      src_a_reg    <= src_a;
      src_b_reg    <= src_b;
      src_b_en_reg <= src_b_en;
      dst_reg      <= dst;
      dst_en_reg   <= dst_en;
    end
  end

  // Capture bank data into the operand registers; held through OUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      op_dst_reg    <= '0;
      op_dst_en_reg <= 1'b0;
    end else if (state_reg == CAPTURE) begin
      op_a_reg      <= line_a;
      op_b_reg      <= src_b_en_reg ? line_b : '0;
      op_dst_reg    <= dst_reg;
      op_dst_en_reg <= dst_en_reg;
    end
  end

  // Next-state and handshake/read-port outputs.
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    read_1EN    = 1'b0;
    read_2EN    = 1'b0;
    read_1      = '0;
    read_2      = '0;
    addr_err    = 1'b0;
    op_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = CHECK;
      end
      CHECK: begin
        if (addr_bad) begin
          addr_err   = 1'b1;
          state_next = IDLE;
        end else if (!hazard) begin
          read_1EN   = 1'b1;
          read_1     = src_a_reg;
          read_2EN   = src_b_en_reg;
          read_2     = src_b_reg;
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = OUT;
      OUT: begin
        op_valid = 1'b1;
        if (op_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign op_a      = op_a_reg;
  assign op_b      = op_b_reg;
  assign op_dst    = op_dst_reg;
  assign op_dst_en = op_dst_en_reg;

`ifdef OPFETCH_STALL_CNT_EN
  logic [15:0] stall_count_reg;

  // Count hazard cycles spent in CHECK, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_reg <= '0;
    else if (state_reg == CHECK && !addr_bad && hazard && stall_count_reg != 16'hFFFF)
      stall_count_reg <= stall_count_reg + 16'd1;
  end

  assign stall_count = stall_count_reg;
`endif

endmodule
